// File: rtl/mine_placer_param.sv
// Parametrised Minesweeper mine placer: an LCG proposes cell indices, and the
// engine keeps in-range, unoccupied, non-safe candidates until n_mines are placed.
module mine_placer_param #(
  parameter  int ROWS      = 5,
  parameter  int COLS      = 5,
  parameter  int SEED_W    = 5,
  parameter  int MAX_TRIES = 255,
  localparam int CELLS     = ROWS * COLS,
  localparam int IDX_W     = $clog2(CELLS),
  localparam int CNT_W     = $clog2(CELLS + 1),
  localparam int TRY_W     = $clog2(MAX_TRIES + 1)
) (
  input  logic              in_clka,
  input  logic              in_rst_n,
  input  logic              in_restart,
  input  logic              in_place,
  input  logic [SEED_W-1:0] in_seed,
  input  logic [SEED_W-1:0] in_mult,
  input  logic [SEED_W-1:0] in_incr,
  input  logic [CNT_W-1:0]  in_n_mines,
  input  logic              in_safe_en,
  input  logic [IDX_W-1:0]  in_safe_idx,
  output logic [CELLS-1:0]  out_mines,
  output logic [CNT_W-1:0]  out_mine_cnt,
  output logic              out_busy,
  output logic              out_place_done,
  output logic              out_error,
  output logic [IDX_W-1:0]  out_last_idx
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_GEN  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  localparam logic [SEED_W:0]  CELLS_X = (SEED_W + 1)'(CELLS);
  localparam logic [CNT_W-1:0] CELLS_C = CNT_W'(CELLS);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);
  localparam logic [CELLS-1:0] ONE_HOT = {{(CELLS - 1){1'b0}}, 1'b1};

  state_t             state_q;
  logic [SEED_W-1:0]  x_q, mult_q, incr_q;
  logic [CNT_W-1:0]   n_mines_q;
  logic               safe_en_q;
  logic [IDX_W-1:0]   safe_idx_q;
  logic [TRY_W-1:0]   tries_q;
  logic [CELLS-1:0]   mines_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q, done_q, error_q;
  logic [IDX_W-1:0]   last_q;

  logic [SEED_W-1:0]  x_d;
  logic [IDX_W-1:0]   cand_idx_s;
  logic [CELLS-1:0]   cand_bit_s;
  logic               in_range_s;
  logic               accept_s;
  logic [CNT_W-1:0]   cnt_d;
  logic [CNT_W-1:0]   limit_s;

  // Next LCG value and the accept/reject decision for it as a candidate
  always_comb begin
    x_d        = x_q * mult_q + incr_q;
    cand_idx_s = x_d[IDX_W-1:0];
    cand_bit_s = ONE_HOT << cand_idx_s;
    in_range_s = ({1'b0, x_d} < CELLS_X);
    accept_s   = in_range_s && ((mines_q & cand_bit_s) == {CELLS{1'b0}}) &&
                 !(safe_en_q && (cand_idx_s == safe_idx_q));
    cnt_d      = cnt_q + CNT_W'(1);
    limit_s    = CELLS_C - CNT_W'(safe_en_q);
  end

  // Placement FSM; restart behaves exactly like reset but synchronously
  always_ff @(posedge in_clka or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      mult_q     <= '0;
      incr_q     <= '0;
      n_mines_q  <= '0;
      safe_en_q  <= 1'b0;
      safe_idx_q <= '0;
      tries_q    <= '0;
      mines_q    <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      last_q     <= '0;
    end else if (in_restart) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      mult_q     <= '0;
      incr_q     <= '0;
      n_mines_q  <= '0;
      safe_en_q  <= 1'b0;
      safe_idx_q <= '0;
      tries_q    <= '0;
      mines_q    <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      last_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (in_place) begin
            state_q    <= ST_INIT;
            busy_q     <= 1'b1;
            x_q        <= in_seed;
            mult_q     <= in_mult;
            incr_q     <= in_incr;
            n_mines_q  <= in_n_mines;
            safe_en_q  <= in_safe_en;
            safe_idx_q <= in_safe_idx;
            mines_q    <= '0;
            cnt_q      <= '0;
            tries_q    <= '0;
            error_q    <= 1'b0;
          end else begin
            state_q <= state_q;
          end
        end
        ST_INIT: begin
          mines_q <= '0;
          cnt_q   <= '0;
          tries_q <= '0;
          error_q <= 1'b0;
          if (n_mines_q > limit_s) begin
            state_q <= ST_ERR;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end else if (n_mines_q == {CNT_W{1'b0}}) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_GEN;
          end
        end
        ST_GEN: begin
          x_q     <= x_d;
          tries_q <= tries_q + TRY_W'(1);
          if (accept_s) begin
            mines_q <= mines_q | cand_bit_s;
            cnt_q   <= cnt_d;
            last_q  <= cand_idx_s;
          end else begin
            cnt_q <= cnt_q;
          end
          // Completion wins over the watchdog when both hit on the same cycle
          if (accept_s && (cnt_d == n_mines_q)) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (tries_q == TRY_LAST) begin
            state_q <= ST_ERR;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end else begin
            state_q <= ST_GEN;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_mines      = mines_q;
  assign out_mine_cnt   = cnt_q;
  assign out_busy       = busy_q;
  assign out_place_done = done_q;
  assign out_error      = error_q;
  assign out_last_idx   = last_q;

endmodule

// File: tb/tb_mine_placer_param.sv
// Directed bench for mine_placer_param: a default 5x5 instance plus a
// MAX_TRIES=16 instance sharing the same stimulus.
module tb_mine_placer_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        restart = 1'b0;
  logic        place = 1'b0;
  logic [4:0]  seed = 5'd0, mult = 5'd0, incr = 5'd0, n_mines = 5'd0, safe_idx = 5'd0;
  logic        safe_en = 1'b0;

  logic [24:0] a_mines, b_mines;
  logic [4:0]  a_cnt, b_cnt, a_last, b_last;
  logic        a_busy, b_busy, a_done, b_done, a_err, b_err;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mine_placer_param dut_a (
    .in_clka(clk), .in_rst_n(rst_n), .in_restart(restart), .in_place(place),
    .in_seed(seed), .in_mult(mult), .in_incr(incr), .in_n_mines(n_mines),
    .in_safe_en(safe_en), .in_safe_idx(safe_idx),
    .out_mines(a_mines), .out_mine_cnt(a_cnt), .out_busy(a_busy),
    .out_place_done(a_done), .out_error(a_err), .out_last_idx(a_last)
  );

  mine_placer_param #(.MAX_TRIES(16)) dut_b (
    .in_clka(clk), .in_rst_n(rst_n), .in_restart(restart), .in_place(place),
    .in_seed(seed), .in_mult(mult), .in_incr(incr), .in_n_mines(n_mines),
    .in_safe_en(safe_en), .in_safe_idx(safe_idx),
    .out_mines(b_mines), .out_mine_cnt(b_cnt), .out_busy(b_busy),
    .out_place_done(b_done), .out_error(b_err), .out_last_idx(b_last)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [4:0] s, input logic [4:0] m, input logic [4:0] c,
                       input logic [4:0] n, input logic se, input logic [4:0] si);
    seed = s; mult = m; incr = c; n_mines = n; safe_en = se; safe_idx = si;
    place = 1'b1;
    tick();
    place = 1'b0;
  endtask

  // cyc counts the start edge as cycle 1 and stops when done or error shows up
  task automatic wait_end(input bit use_b, input int limit, output int cyc);
    cyc = 1;
    for (int i = 0; i < limit; i++) begin
      tick();
      cyc++;
      if (use_b ? (b_done | b_err) : (a_done | a_err)) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    total++; if (a_mines !== 25'd0) $display("FAIL reset_mines got %h want 0", a_mines); else passed++;
    total++; if ({a_cnt, a_last} !== 10'd0) $display("FAIL reset_cnt_last got %h want 0", {a_cnt, a_last}); else passed++;
    total++; if ({a_busy, a_done, a_err} !== 3'b000) $display("FAIL reset_flags got %b want 000", {a_busy, a_done, a_err}); else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int cyc;
    start(5'd0, 5'd5, 5'd13, 5'd3, 1'b0, 5'd0);
    total++; if (a_busy !== 1'b1) $display("FAIL basic_busy got %b want 1", a_busy); else passed++;
    wait_end(1'b0, 60, cyc);
    total++; if (cyc !== 5) $display("FAIL basic_latency got %0d want 5", cyc); else passed++;
    total++; if (a_done !== 1'b1) $display("FAIL basic_done got %b want 1", a_done); else passed++;
    total++; if (a_mines !== 25'h0086000) $display("FAIL basic_mines got %h want 0086000", a_mines); else passed++;
    total++; if (a_cnt !== 5'd3 || a_last !== 5'd19) $display("FAIL basic_cnt_last got %0d/%0d want 3/19", a_cnt, a_last); else passed++;
    tick();
    total++; if (a_done !== 1'b0 || a_mines !== 25'h0086000) $display("FAIL basic_pulse_hold got %b/%h want 0/0086000", a_done, a_mines); else passed++;
  endtask

  task automatic test_back_to_back();
    int cyc;
    start(5'd0, 5'd5, 5'd13, 5'd3, 1'b1, 5'd14);
    wait_end(1'b0, 60, cyc);
    total++; if (cyc !== 6) $display("FAIL safe_latency got %0d want 6", cyc); else passed++;
    total++; if (a_mines !== 25'h0083000) $display("FAIL safe_mines got %h want 0083000", a_mines); else passed++;
    total++; if (a_err !== 1'b0 || a_done !== 1'b1) $display("FAIL safe_flags got err %b done %b want 0 1", a_err, a_done); else passed++;
    total++; if (a_last !== 5'd12) $display("FAIL safe_last got %0d want 12", a_last); else passed++;
  endtask

  task automatic test_full();
    int cyc;
    start(5'd0, 5'd5, 5'd13, 5'd25, 1'b0, 5'd0);
    wait_end(1'b0, 60, cyc);
    total++; if (cyc !== 34) $display("FAIL full_latency got %0d want 34", cyc); else passed++;
    total++; if (a_mines !== 25'h1FFFFFF || a_cnt !== 5'd25) $display("FAIL full_board got %h/%0d want 1FFFFFF/25", a_mines, a_cnt); else passed++;
    total++; if (a_last !== 5'd0 || a_done !== 1'b1) $display("FAIL full_last got %0d done %b want 0 1", a_last, a_done); else passed++;
  endtask

  task automatic test_bounds();
    int cyc;
    start(5'd0, 5'd5, 5'd13, 5'd25, 1'b1, 5'd3);
    wait_end(1'b0, 20, cyc);
    total++; if (cyc !== 2 || a_err !== 1'b1) $display("FAIL toomany_err got cyc %0d err %b want 2 1", cyc, a_err); else passed++;
    total++; if (a_mines !== 25'd0 || a_done !== 1'b0) $display("FAIL toomany_mines got %h done %b want 0 0", a_mines, a_done); else passed++;
    start(5'd0, 5'd5, 5'd13, 5'd0, 1'b0, 5'd0);
    wait_end(1'b0, 20, cyc);
    total++; if (cyc !== 2 || a_done !== 1'b1) $display("FAIL zero_done got cyc %0d done %b want 2 1", cyc, a_done); else passed++;
    total++; if (a_mines !== 25'd0 || a_err !== 1'b0) $display("FAIL zero_mines got %h err %b want 0 0", a_mines, a_err); else passed++;
  endtask

  task automatic test_watchdog();
    int cyc;
    start(5'd7, 5'd1, 5'd0, 5'd2, 1'b0, 5'd0);
    wait_end(1'b1, 60, cyc);
    total++; if (cyc !== 18) $display("FAIL wdog_latency got %0d want 18", cyc); else passed++;
    total++; if (b_err !== 1'b1 || b_done !== 1'b0) $display("FAIL wdog_flags got err %b done %b want 1 0", b_err, b_done); else passed++;
    total++; if (b_mines !== 25'h0000080 || b_cnt !== 5'd1) $display("FAIL wdog_partial got %h/%0d want 0000080/1", b_mines, b_cnt); else passed++;
    total++; if (a_busy !== 1'b1) $display("FAIL wdog_big_busy got %b want 1", a_busy); else passed++;
  endtask

  task automatic test_restart();
    int cyc;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    total++; if (a_busy !== 1'b0 || a_mines !== 25'd0) $display("FAIL rst_busy_mines got %b/%h want 0/0", a_busy, a_mines); else passed++;
    total++; if (a_cnt !== 5'd0 || a_last !== 5'd0) $display("FAIL rst_cnt_last got %0d/%0d want 0/0", a_cnt, a_last); else passed++;
    place = 1'b1; restart = 1'b1;
    tick();
    place = 1'b0; restart = 1'b0;
    total++; if (a_busy !== 1'b0) $display("FAIL rst_over_place got %b want 0", a_busy); else passed++;
    start(5'd0, 5'd5, 5'd13, 5'd25, 1'b0, 5'd0);
    for (int i = 0; i < 5; i++) tick();
    total++; if (a_busy !== 1'b1 || a_mines === 25'd0) $display("FAIL mid_gen got busy %b mines %h want 1 nonzero", a_busy, a_mines); else passed++;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    total++; if (a_busy !== 1'b0 || a_mines !== 25'd0 || a_cnt !== 5'd0) $display("FAIL restart_clear got %b/%h/%0d want 0/0/0", a_busy, a_mines, a_cnt); else passed++;
    start(5'd0, 5'd5, 5'd13, 5'd3, 1'b0, 5'd0);
    tick();
    seed = 5'd7; mult = 5'd1; incr = 5'd0; n_mines = 5'd25; place = 1'b1;
    tick();
    place = 1'b0;
    wait_end(1'b0, 60, cyc);
    total++; if (a_mines !== 25'h0086000 || a_last !== 5'd19) $display("FAIL replay_restart got %h/%0d want 0086000/19", a_mines, a_last); else passed++;
    start(5'd0, 5'd5, 5'd13, 5'd25, 1'b0, 5'd0);
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    total++; if (a_busy !== 1'b0 || a_mines !== 25'd0 || a_cnt !== 5'd0) $display("FAIL async_clear got %b/%h/%0d want 0/0/0", a_busy, a_mines, a_cnt); else passed++;
    tick();
    rst_n = 1'b1;
    tick();
    start(5'd0, 5'd5, 5'd13, 5'd3, 1'b0, 5'd0);
    wait_end(1'b0, 60, cyc);
    total++; if (cyc !== 5 || a_mines !== 25'h0086000 || a_cnt !== 5'd3) $display("FAIL replay_reset got cyc %0d %h/%0d want 5 0086000/3", cyc, a_mines, a_cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_full();
    test_bounds();
    test_watchdog();
    test_restart();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
